alu_share_arb: RTL and testbench

- Two-requester arbiter and scheduler for the shared single-cycle integer ALU.
- Typical requesters: EX-stage integer ops (port 0) and the address-generation/auxiliary unit (port 1).
- Each cycle it grants at most one request, drives the ALU operand/op bus, and captures the combinational ALU result into a per-requester response register.
- Responses use valid/ready handshakes; round-robin fairness applies on conflict.

---
 rtl/alu_share_arb.sv | 145 ++++++++++++++
 tb/tb_alu_share_arb.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: two-port round-robin scheduler for the shared single-cycle integer ALU.
// Define ALU_SHARE_ARB_PERF_EN to add the saturating conflict_cnt output.

module alu_share_arb_slot #(
  parameter int TAG_W  = 4,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              grant,
  input  logic              rsp_ready,
  input  logic [DATA_W-1:0] result,
  input  logic [TAG_W-1:0]  tag,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_result,
  output logic [TAG_W-1:0]  rsp_tag
);
  // A grant wins over a drain in the same cycle: the new result overwrites.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
    end else if (grant) begin
      rsp_valid  <= 1'b1;
      rsp_result <= result;
      rsp_tag    <= tag;
    end else if (rsp_ready) begin
      rsp_valid  <= 1'b0;
    end
  end
endmodule

module alu_share_arb #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [11:0]      req0_op,
  input  logic [31:0]      req0_src1,
  input  logic [31:0]      req0_src2,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [11:0]      req1_op,
  input  logic [31:0]      req1_src1,
  input  logic [31:0]      req1_src2,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [31:0]      rsp0_result,
  output logic [TAG_W-1:0] rsp0_tag,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [31:0]      rsp1_result,
  output logic [TAG_W-1:0] rsp1_tag,
  output logic [11:0]      alu_op,
  output logic [31:0]      alu_src1,
  output logic [31:0]      alu_src2,
  input  logic [31:0]      alu_result
`ifdef ALU_SHARE_ARB_PERF_EN
  ,
  output logic [31:0]      conflict_cnt
`endif
);
  localparam int NUM_REQ = 2;
  localparam int OP_W    = 12;
  localparam int DATA_W  = 32;

  typedef struct packed {
    logic              valid;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [TAG_W-1:0]  tag;
  } req_t;

  req_t [NUM_REQ-1:0]                req;
  logic [NUM_REQ-1:0]                rsp_valid, rsp_ready, elig, grant;
  logic [NUM_REQ-1:0][DATA_W-1:0]    rsp_result;
  logic [NUM_REQ-1:0][TAG_W-1:0]     rsp_tag;
  logic                              prio;

  assign req[0] = '{valid: req0_valid, op: req0_op, src1: req0_src1, src2: req0_src2, tag: req0_tag};
  assign req[1] = '{valid: req1_valid, op: req1_op, src1: req1_src1, src2: req1_src2, tag: req1_tag};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // A requester is eligible only if its response slot is empty or draining now.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slot
    assign elig[g] = req[g].valid & (~rsp_valid[g] | rsp_ready[g]);

    alu_share_arb_slot #(.TAG_W(TAG_W), .DATA_W(DATA_W)) u_slot (
      .clk        (clk),
      .resetn     (resetn),
      .grant      (grant[g]),
      .rsp_ready  (rsp_ready[g]),
      .result     (alu_result),
      .tag        (req[g].tag),
      .rsp_valid  (rsp_valid[g]),
      .rsp_result (rsp_result[g]),
      .rsp_tag    (rsp_tag[g])
    );
  end

  // prio names the requester that wins the next conflict.
  assign grant[0] = elig[0] & (~elig[1] | ~prio);
  assign grant[1] = elig[1] & (~elig[0] |  prio);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)       prio <= 1'b0;
    else if (grant[0]) prio <= 1'b1;
    else if (grant[1]) prio <= 1'b0;
  end

  always_comb begin
    alu_op   = '0;
    alu_src1 = '0;
    alu_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        alu_op   = req[i].op;
        alu_src1 = req[i].src1;
        alu_src2 = req[i].src2;
      end
    end
  end

`ifdef ALU_SHARE_ARB_PERF_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)                                     conflict_cnt <= '0;
    else if (&elig && conflict_cnt != 32'hFFFF_FFFF) conflict_cnt <= conflict_cnt + 32'd1;
  end
`endif

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign rsp0_valid  = rsp_valid[0];
  assign rsp1_valid  = rsp_valid[1];
  assign rsp0_result = rsp_result[0];
  assign rsp1_result = rsp_result[1];
  assign rsp0_tag    = rsp_tag[0];
  assign rsp1_tag    = rsp_tag[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: table-driven arbitration checks plus a response scoreboard.
module tb_alu_share_arb;
  localparam int TAG_W = 4;
  localparam logic [11:0] OP_ADD = 12'h001, OP_SUB = 12'h002, OP_SLT = 12'h004, OP_OR = 12'h020;

  logic clk = 1'b0, resetn;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [11:0] req0_op, req1_op, alu_op;
  logic [31:0] req0_src1, req0_src2, req1_src1, req1_src2;
  logic [TAG_W-1:0] req0_tag, req1_tag, rsp0_tag, rsp1_tag;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_result, rsp1_result, alu_src1, alu_src2, alu_result;
`ifdef ALU_SHARE_ARB_PERF_EN
  logic [31:0] conflict_cnt;
`endif

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_share_arb #(.TAG_W(TAG_W)) dut (
    .clk(clk), .resetn(resetn),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_src1(req0_src1), .req0_src2(req0_src2), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_src1(req1_src1), .req1_src2(req1_src2), .req1_tag(req1_tag),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_tag(rsp0_tag),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_tag(rsp1_tag),
    .alu_op(alu_op), .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_result(alu_result)
`ifdef ALU_SHARE_ARB_PERF_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );

  // External ALU model: bit0 add, bit1 sub, bit2 slt, bit5 or; other ops unused here.
  always_comb begin
    alu_result = '0;
    case (alu_op)
      OP_ADD:  alu_result = alu_src1 + alu_src2;
      OP_SUB:  alu_result = alu_src1 - alu_src2;
      OP_SLT:  alu_result = {31'd0, $signed(alu_src1) < $signed(alu_src2)};
      OP_OR:   alu_result = alu_src1 | alu_src2;
      default: alu_result = '0;
    endcase
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  typedef struct { logic [31:0] res; logic [TAG_W-1:0] tag; } exp_t;
  exp_t q0[$], q1[$];
  exp_t e0, e1;

  always @(negedge clk) begin
    if (resetn === 1'b1) begin
      if (rsp0_valid && rsp0_ready) begin
        if (q0.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp0_unexpected got %0h want none", rsp0_result);
        end else begin
          e0 = q0.pop_front();
          chk("rsp0_result", rsp0_result, e0.res);
          chk("rsp0_tag", {28'd0, rsp0_tag}, {28'd0, e0.tag});
        end
      end
      if (rsp1_valid && rsp1_ready) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp1_unexpected got %0h want none", rsp1_result);
        end else begin
          e1 = q1.pop_front();
          chk("rsp1_result", rsp1_result, e1.res);
          chk("rsp1_tag", {28'd0, rsp1_tag}, {28'd0, e1.tag});
        end
      end
    end
  end

  typedef struct {
    string nm;
    logic v0; logic [11:0] op0; logic [31:0] a0, b0; logic [3:0] t0;
    logic v1; logic [11:0] op1; logic [31:0] a1, b1; logic [3:0] t1;
    logic rr0, rr1;
    logic eg0, eg1, ev0, ev1;
    logic [31:0] er0, er1;
  } vec_t;

  function automatic vec_t mk(input string nm,
      input logic v0, input logic [11:0] op0, input logic [31:0] a0, b0, input logic [3:0] t0,
      input logic v1, input logic [11:0] op1, input logic [31:0] a1, b1, input logic [3:0] t1,
      input logic rr0, rr1, eg0, eg1, ev0, ev1, input logic [31:0] er0, er1);
    vec_t v;
    v.nm = nm; v.v0 = v0; v.op0 = op0; v.a0 = a0; v.b0 = b0; v.t0 = t0;
    v.v1 = v1; v.op1 = op1; v.a1 = a1; v.b1 = b1; v.t1 = t1;
    v.rr0 = rr0; v.rr1 = rr1; v.eg0 = eg0; v.eg1 = eg1; v.ev0 = ev0; v.ev1 = ev1;
    v.er0 = er0; v.er1 = er1;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_op = v.op0; req0_src1 = v.a0; req0_src2 = v.b0; req0_tag = v.t0;
    req1_valid = v.v1; req1_op = v.op1; req1_src1 = v.a1; req1_src2 = v.b1; req1_tag = v.t1;
    rsp0_ready = v.rr0; rsp1_ready = v.rr1;
    if (v.eg0) q0.push_back('{res: v.er0, tag: v.t0});
    if (v.eg1) q1.push_back('{res: v.er1, tag: v.t1});
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_op = '0; req0_src1 = '0; req0_src2 = '0; req0_tag = '0;
    req1_valid = 0; req1_op = '0; req1_src1 = '0; req1_src2 = '0; req1_tag = '0;
    rsp0_ready = 1; rsp1_ready = 1;
  endtask

  vec_t vt[16];
  logic [11:0] xop;
  logic [31:0] xs1;

  initial begin
    vt[0]  = mk("conf0", 1, OP_SUB, 10, 3, 1, 1, OP_OR, 32'hF0, 32'h0F, 2, 1, 1, 1, 0, 0, 0, 7, 0);
    vt[1]  = mk("conf1", 1, OP_SUB, 10, 3, 1, 1, OP_OR, 32'hF0, 32'h0F, 2, 1, 1, 0, 1, 1, 0, 0, 32'hFF);
    vt[2]  = mk("conf2", 1, OP_SUB, 10, 3, 1, 1, OP_OR, 32'hF0, 32'h0F, 2, 1, 1, 1, 0, 0, 1, 7, 0);
    vt[3]  = mk("conf3", 1, OP_SUB, 10, 3, 1, 1, OP_OR, 32'hF0, 32'h0F, 2, 1, 1, 0, 1, 1, 0, 0, 32'hFF);
    vt[4]  = mk("add",   1, OP_ADD, 5, 7, 3, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 1, 12, 0);
    vt[5]  = mk("idle5", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    vt[6]  = mk("fill1", 0, 0, 0, 0, 0, 1, OP_OR, 1, 2, 5, 1, 0, 0, 1, 0, 0, 0, 3);
    vt[7]  = mk("bp0",   1, OP_ADD, 1, 2, 6, 1, OP_OR, 32'h10, 32'h01, 7, 1, 0, 1, 0, 0, 1, 3, 0);
    vt[8]  = mk("bp1",   1, OP_ADD, 1, 2, 6, 1, OP_OR, 32'h10, 32'h01, 7, 1, 0, 1, 0, 1, 1, 3, 0);
    vt[9]  = mk("bp2",   1, OP_ADD, 1, 2, 6, 1, OP_OR, 32'h10, 32'h01, 7, 1, 0, 1, 0, 1, 1, 3, 0);
    vt[10] = mk("rel",   1, OP_ADD, 1, 2, 6, 1, OP_OR, 32'h10, 32'h01, 7, 1, 1, 0, 1, 1, 1, 0, 32'h11);
    vt[11] = mk("idle11",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0);
    vt[12] = mk("b2b0",  1, OP_ADD, 1, 1, 8, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 2, 0);
    vt[13] = mk("b2b1",  1, OP_SLT, 32'hFFFF_FFFF, 1, 9, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0);
    vt[14] = mk("idle14",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0);
    vt[15] = mk("idle15",0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);

    idle_inputs();
    resetn = 0;
    repeat (2) @(negedge clk);
    chk("rst rsp0_valid", {31'd0, rsp0_valid}, 0);
    chk("rst rsp1_valid", {31'd0, rsp1_valid}, 0);
    chk("rst rsp0_result", rsp0_result, 0);
    chk("rst rsp1_tag", {28'd0, rsp1_tag}, 0);
    @(posedge clk); #1 resetn = 1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d rsp0_valid", i), {31'd0, rsp0_valid}, 0);
      chk($sformatf("idle%0d rsp1_valid", i), {31'd0, rsp1_valid}, 0);
      chk($sformatf("idle%0d alu_op", i), {20'd0, alu_op}, 0);
      chk($sformatf("idle%0d readys", i), {30'd0, req1_ready, req0_ready}, 0);
    end
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      drive(vt[i]);
      @(negedge clk);
      xop = vt[i].eg0 ? vt[i].op0 : (vt[i].eg1 ? vt[i].op1 : 12'd0);
      xs1 = vt[i].eg0 ? vt[i].a0  : (vt[i].eg1 ? vt[i].a1  : 32'd0);
      chk({vt[i].nm, " req0_ready"}, {31'd0, req0_ready}, {31'd0, vt[i].eg0});
      chk({vt[i].nm, " req1_ready"}, {31'd0, req1_ready}, {31'd0, vt[i].eg1});
      chk({vt[i].nm, " alu_op"}, {20'd0, alu_op}, {20'd0, xop});
      chk({vt[i].nm, " alu_src1"}, alu_src1, xs1);
      chk({vt[i].nm, " rsp0_valid"}, {31'd0, rsp0_valid}, {31'd0, vt[i].ev0});
      chk({vt[i].nm, " rsp1_valid"}, {31'd0, rsp1_valid}, {31'd0, vt[i].ev1});
`ifdef ALU_SHARE_ARB_PERF_EN
      if (i == 4) chk("conflict_cnt after 4", conflict_cnt, 4);
`endif
      @(posedge clk); #1;
    end
`ifdef ALU_SHARE_ARB_PERF_EN
    chk("conflict_cnt end", conflict_cnt, 5);
`endif

    // Leave a held response in slot 0 and prio=1, then reset asynchronously.
    idle_inputs();
    req0_valid = 1; req0_op = OP_ADD; req0_src1 = 2; req0_src2 = 2; req0_tag = 1; rsp0_ready = 0;
    q0.push_back('{res: 4, tag: 1});
    @(negedge clk);
    chk("pre_rst req0_ready", {31'd0, req0_ready}, 1);
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    chk("pre_rst rsp0_valid", {31'd0, rsp0_valid}, 1);
    #2 resetn = 0;
    #1;
    chk("async rsp0_valid", {31'd0, rsp0_valid}, 0);
    chk("async rsp0_result", rsp0_result, 0);
    q0.delete(); q1.delete();
    @(posedge clk); #1 resetn = 1;
    rsp0_ready = 1;
    req0_valid = 1; req0_op = OP_ADD; req0_src1 = 9; req0_src2 = 9; req0_tag = 4'hA;
    req1_valid = 1; req1_op = OP_OR;  req1_src1 = 1; req1_src2 = 4; req1_tag = 4'h5;
    q0.push_back('{res: 18, tag: 4'hA});
    @(negedge clk);
    chk("post_rst req0_ready", {31'd0, req0_ready}, 1);
    chk("post_rst req1_ready", {31'd0, req1_ready}, 0);
    @(posedge clk); #1;
    idle_inputs();
    repeat (3) @(negedge clk);
    chk("q0 drained", q0.size(), 0);
    chk("q1 drained", q1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
